// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the two-road traffic controller.
//   state_t      - controller states (RA/RB exist only with TRAFFIC_ALLRED_EN)
//   PH_*         - phase codes shown on display digit 3
//   seg7()       - active-low 7-segment table {dp,g..a} for 0-9, blank otherwise
//   next_phase() - phase sequence; TRAFFIC_ALLRED_EN inserts the all-red states
//   MAX_T        - largest phase duration in ticks
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AG   = 3'd1,
    AY   = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    RA   = 3'd5,
    RB   = 3'd6
  } state_t;

  localparam logic [3:0] PH_IDLE   = 4'd0;
  localparam logic [3:0] PH_AG     = 4'd1;
  localparam logic [3:0] PH_AY     = 4'd2;
  localparam logic [3:0] PH_BG     = 4'd3;
  localparam logic [3:0] PH_BY     = 4'd4;
  localparam logic [3:0] PH_ALLRED = 4'd5;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         MAX_T     = 99;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] phase_code(input state_t s);
    case (s)
      AG:      return PH_AG;
      AY:      return PH_AY;
      BG:      return PH_BG;
      BY:      return PH_BY;
      RA, RB:  return PH_ALLRED;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      AG:      return AY;
`ifdef TRAFFIC_ALLRED_EN
      AY:      return RA;
      RA:      return BG;
      BG:      return BY;
      BY:      return RB;
      RB:      return AG;
`else
      AY:      return BG;
      BG:      return BY;
      BY:      return AG;
`endif
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_param_seg_scan4.sv
// seg_scan4: 4-digit multiplexed 7-segment driver.
//   clk, clr     - clock, asynchronous active-low reset
//   digits[3:0]  - one 4-bit value per digit position
//   blank[3:0]   - 1 = digit position shown blank
//   an[3:0]      - digit enables, active-low, scanned 0->1->2->3
//   seg[7:0]     - segments {dp,g..a}, active-low, dp always off
// Each digit slot lasts SCAN_DIV clocks; an/seg are registered.
module seg_scan4
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV = 25_000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [3:0][3:0] digits,
  input  logic [3:0]      blank,
  output logic [3:0]      an,
  output logic [7:0]      seg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] sc;
  logic [1:0]    sel;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sc  <= '0;
      sel <= '0;
      an  <= 4'hF;
      seg <= SEG_BLANK;
    end else begin
      if (sc == SW'(SCAN_DIV - 1)) begin
        sc  <= '0;
        sel <= sel + 2'd1;
      end else begin
        sc  <= sc + 1'b1;
      end
      an  <= ~(4'b0001 << sel);
      seg <= blank[sel] ? SEG_BLANK : seg7(digits[sel]);
    end
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: parametrised two-road traffic-light controller.
//   clk                  - board clock
//   clr                  - asynchronous active-low reset
//   start                - 1 = run, 0 = return to IDLE
//   stopa / stopb        - hold road A / road B green (both = freeze)
//   pause                - freeze state, countdown and prescaler
//   r1,g1,y1 / r2,g2,y2  - road A / road B lamps, active-high, registered
//   AN[3:0], Seg[7:0]    - multiplexed display: digits 1:0 countdown (BCD),
//                          digit 2 blank, digit 3 phase code
// Optional build macro TRAFFIC_ALLRED_EN adds 1-tick all-red states after
// each yellow phase.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GA_T     = 30,
  parameter int YA_T     = 5,
  parameter int GB_T     = 20,
  parameter int YB_T     = 5,
  parameter int SCAN_DIV = 25_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stopa,
  input  logic       stopb,
  input  logic       pause,
  output logic       r1,
  output logic       g1,
  output logic       y1,
  output logic       r2,
  output logic       g2,
  output logic       y2,
  output logic [3:0] AN,
  output logic [7:0] Seg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(MAX_T + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pre, pre_n;
  logic          frozen, tick, hold;

  function automatic logic [CW-1:0] dur(input state_t s);
    case (s)
      AG:      return CW'(GA_T);
      AY:      return CW'(YA_T);
      BG:      return CW'(GB_T);
      BY:      return CW'(YB_T);
      default: return CW'(1);
    endcase
  endfunction

  assign frozen = pause | (stopa & stopb);
  assign tick   = (pre == PW'(TICK_DIV - 1));
  // A single stop request pins the countdown of its own green phase only.
  assign hold   = (stopa && state == AG) || (stopb && state == BG);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pre_n   = pre;
    if (!start) begin
      state_n = IDLE;
      cnt_n   = '0;
      pre_n   = '0;
    end else if (frozen) begin
      // everything holds
    end else if (state == IDLE) begin
      state_n = AG;
      cnt_n   = dur(AG);
      pre_n   = '0;
    end else if (stopa && state == BG) begin
      // Forced phase changes restart the prescaler so the new phase
      // lasts its full duration, like a tick-driven change.
      state_n = BY;
      cnt_n   = dur(BY);
      pre_n   = '0;
    end else if (stopb && state == AG) begin
      state_n = AY;
      cnt_n   = dur(AY);
      pre_n   = '0;
    end else begin
      pre_n = tick ? '0 : pre + 1'b1;
      if (tick && !hold) begin
        if (cnt > CW'(1)) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = next_phase(state);
          cnt_n   = dur(next_phase(state));
        end
      end
    end
  end

  // ---- state / countdown / lamp registers ----
  // Lamps are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      pre   <= '0;
      r1    <= 1'b1;
      g1    <= 1'b0;
      y1    <= 1'b0;
      r2    <= 1'b1;
      g2    <= 1'b0;
      y2    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pre   <= pre_n;
      r1    <= state_n inside {IDLE, BG, BY, RA, RB};
      g1    <= (state_n == AG);
      y1    <= (state_n == AY);
      r2    <= state_n inside {IDLE, AG, AY, RA, RB};
      g2    <= (state_n == BG);
      y2    <= (state_n == BY);
    end
  end

  logic [3:0]      tens, ones;
  logic [3:0][3:0] digits;

  assign tens   = 4'(cnt / CW'(10));
  assign ones   = 4'(cnt % CW'(10));
  assign digits = {phase_code(state), 4'hF, tens, ones};

  // ---- display scan ----
  seg_scan4 #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .clr    (clr),
    .digits (digits),
    .blank  (4'b0100),
    .an     (AN),
    .seg    (Seg)
  );

endmodule
